// File: rtl/comb_pkg.sv
// rtl/comb_pkg.sv - shared widths, row type and FSM encoding for the colex unranker
package comb_pkg;

  localparam int N_W     = 4;
  localparam int R_W     = 13;
  localparam int ROW_LEN = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BUILD,
    ST_CHECK,
    ST_DECODE,
    ST_DONE
  } state_t;

  // One Pascal row: entry j holds C(k, j) for the current row index k
  typedef logic [ROW_LEN-1:0][R_W-1:0] row_t;

endpackage

// File: rtl/pascal_row.sv
// rtl/pascal_row.sv - Pascal-row register that steps up or down one row per cycle
module pascal_row
  import comb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic init,
  input  logic up,
  input  logic down,
  output row_t row,
  output row_t lower
);

  // Row below the current one: C(k-1,j) = C(k,j) - C(k-1,j-1); the running
  // difference is kept in a temporary so the chain has no self-reference
  always_comb begin
    logic [R_W-1:0] prev;
    lower    = '0;
    prev     = R_W'(1);
    lower[0] = R_W'(1);
    for (int j = 1; j < ROW_LEN; j++) begin
      prev     = row[j] - prev;
      lower[j] = prev;
    end
  end

  // Row register: seed with row 0, add neighbours to climb, load lower to descend
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row <= '0;
    end else if (init) begin
      row <= row_t'(1);
    end else if (up) begin
      for (int j = 1; j < ROW_LEN; j++) begin
        row[j] <= row[j] + row[j-1];
      end
    end else if (down) begin
      row <= lower;
    end
  end

endmodule

// File: rtl/comb_unranker.sv
// rtl/comb_unranker.sv - turns a colex rank r < C(n,m) back into an m-subset mask of {0..n-1}
module comb_unranker
  import comb_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [N_W-1:0]     n,
  input  logic [N_W-1:0]     m,
  input  logic [R_W-1:0]     r,
  output logic               ready,
  output logic               done,
  output logic               err,
  output logic [ROW_LEN-1:0] mask
);

  state_t         state;
  logic [N_W-1:0] n_q;
  logic [N_W-1:0] m_q;
  logic [R_W-1:0] r_q;
  logic [N_W-1:0] k;
  logic [N_W-1:0] k_dec;
  logic [N_W-1:0] m_rem;
  logic [R_W-1:0] r_rem;

  logic row_init;
  logic row_up;
  logic row_down;
  row_t row;
  row_t lower;

  // Row-register controls follow the FSM state directly
  always_comb begin
    row_init = (state == ST_IDLE) && start;
    row_up   = (state == ST_BUILD) && (k != n_q);
    row_down = (state == ST_DECODE);
    k_dec    = k - N_W'(1);
  end

  pascal_row u_row (
    .clk   (clk),
    .rst   (rst),
    .init  (row_init),
    .up    (row_up),
    .down  (row_down),
    .row   (row),
    .lower (lower)
  );

  // Control FSM: build row n, validate r against C(n,m), then peel one element per row going down
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      ready <= 1'b1;
      done  <= 1'b0;
      err   <= 1'b0;
      mask  <= '0;
      n_q   <= '0;
      m_q   <= '0;
      r_q   <= '0;
      k     <= '0;
      m_rem <= '0;
      r_rem <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            n_q   <= n;
            m_q   <= m;
            r_q   <= r;
            k     <= '0;
            mask  <= '0;
            err   <= 1'b0;
            ready <= 1'b0;
            state <= ST_BUILD;
          end
        end
        ST_BUILD: begin
          if (k == n_q) begin
            state <= ST_CHECK;
          end else begin
            k <= k + N_W'(1);
          end
        end
        ST_CHECK: begin
          // row[m] is zero when m > n, so the rank compare alone already rejects it
          if ((m_q > n_q) || (r_q >= row[m_q])) begin
            err   <= 1'b1;
            state <= ST_DONE;
          end else begin
            m_rem <= m_q;
            r_rem <= r_q;
            state <= (k == '0) ? ST_DONE : ST_DECODE;
          end
        end
        ST_DECODE: begin
          // Element k-1 is taken when C(k-1, m_rem) still fits in the remaining rank
          if (lower[m_rem] <= r_rem) begin
            mask[k_dec] <= 1'b1;
            r_rem       <= r_rem - lower[m_rem];
            m_rem       <= m_rem - N_W'(1);
          end
          k <= k_dec;
          if (k == N_W'(1)) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          done  <= 1'b1;
          ready <= 1'b1;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/comb_unranker.md
Name: comb_unranker

Overview:
- Inverse of the stack-based C(n,m) counter.
- Given n, m and a rank r, it produces the m-subset of {0..n-1} that has colex rank r.
- Rank definition: rank = sum over i=1..m of C(c_i, i), with c_1 < c_2 < ... < c_m.
- Sits next to the combination counter: the counter produces C(n,m); this block turns any r < C(n,m) back into a subset mask.
- Uses an internal Pascal-row register. The row is built upward to n, then unwound downward one row per cycle during decode.

Parameters:
- N_W, 4, width of n and m. Maximum n = 2^N_W - 1 = 15.
- R_W, 13, width of the rank and of the binomial entries. C(15,7) = 6435 fits.
- ROW_LEN, 16, number of Pascal-row entries (2^N_W).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  request pulse; sampled only when ready = 1.
- n  in  N_W  set size; captured on an accepted start.
- m  in  N_W  subset size; captured on an accepted start.
- r  in  R_W  rank; captured on an accepted start.
- ready  out  1  high in IDLE only.
- done  out  1  one-cycle pulse when the result is valid.
- err  out  1  set with done when the request is illegal; held until the next accepted start.
- mask  out  ROW_LEN  bit i = 1 means element i is in the subset; held until the next accepted start.

Behaviour:
- Reset (rst = 0, asynchronous): state IDLE, ready = 1, done = 0, err = 0, mask = 0, row = 0, internal counters = 0.
  - Reset mid-operation aborts the request; no done is issued.
- IDLE, on start = 1:
  - Capture n, m, r into internal registers.
  - Load the row with row[0] = 1, all other entries 0.
  - Set k = 0, clear mask and err.
  - Go to BUILD.
  - start outside IDLE is ignored.
- BUILD:
  - If k == n: go to CHECK.
  - Otherwise, in parallel: row[j] <= row[j] + row[j-1] for j = 1..15 (row[0] stays 1), and k <= k + 1.
  - Takes n+1 cycles.
  - Sums wrap modulo 2^R_W, but all entries of rows up to 15 fit.
- CHECK (1 cycle):
  - If m > n or r >= row[m]: err <= 1, go to DONE. The m > n case is covered naturally because row[m] = 0.
  - Otherwise set m_rem = m, r_rem = r, go to DECODE.
- DECODE (exactly n cycles; k runs n..1):
  - Combinationally derive the lower row L (row k-1): L[0] = 1, L[j] = row[j] - L[j-1], for j = 1..15.
  - If L[m_rem] <= r_rem: set mask[k-1], r_rem -= L[m_rem], m_rem -= 1.
  - Then row <= L, k <= k - 1.
  - When m_rem = 0, L[0] = 1 > r_rem = 0, so no further bits are set.
  - When k reaches 0, go to DONE.
- DONE (1 cycle): done = 1, then go to IDLE with ready = 1.
- Latency:
  - Legal request: done is asserted 2n+3 cycles after the accepting edge (n = 0 gives 3).
  - Error request: n+3 cycles.
- Invariants:
  - popcount(mask) == m when err = 0.
  - r_rem == 0 at DONE when err = 0.

Decomposition:
- Package comb_pkg holds N_W, R_W, ROW_LEN and the state encoding (IDLE, BUILD, CHECK, DECODE, DONE).
- Sub-module pascal_row holds the 16 x R_W row register.
  - Inputs: init, up, down.
  - Outputs: the current row and the combinational L chain.
- The top level keeps the FSM, the k / m_rem / r_rem registers and mask.

Test Plan:
- n=5, m=2, r=0 -> mask 0x0003, err=0, done exactly 13 cycles after start.
- n=5, m=2, r=4 -> mask 0x000A; r=9 -> mask 0x0018.
- n=5, m=2, r=10 -> err=1, mask 0x0000, done 8 cycles after start; n=3, m=4, r=0 -> err=1.
- n=15, m=7, r=6434 -> mask 0x7F00; n=15, m=7, r=0 -> mask 0x007F; n=0, m=0, r=0 -> mask 0, done 3 cycles after start.
- Exhaustive: for all r in 0..C(8,3)-1 = 0..55 at n=8, m=3 -> 56 distinct masks, each with popcount 3, matching a reference colex model.
- start pulsed during DECODE is ignored. rst dropped mid-BUILD -> ready=1, done=0, mask=0 immediately; a following request completes correctly.
